// File: rtl/gpu_cpuvram_cmd_unpack_if.sv
// Handshake bundle between the GP0 decoder/FIFO, the A0h unpacker and the
// CPU->VRAM write engine. "master" is the surrounding system, "slave" is the unpacker.
interface gpu_cpuvram_cmd_unpack_if #(
  parameter int FIFO_W = 32
);
  logic              start;
  logic              set_mask;
  logic              check_mask;

  logic              fifo_valid;
  logic [FIFO_W-1:0] fifo_data;
  logic              fifo_pop;

  logic              req_valid;
  logic [15:0]       req_x;
  logic [15:0]       req_y;
  logic [15:0]       req_sizex;
  logic [15:0]       req_sizey;
  logic              req_set_mask;
  logic              req_use_mask;
  logic              req_accept;

  logic              data_valid_l;
  logic [15:0]       data_pixel_l;
  logic              data_valid_r;
  logic [15:0]       data_pixel_r;
  logic              data_accept_l;
  logic              data_accept_r;

  logic              engine_done;
  logic              busy;
  logic              done;

  modport master (
    output start, set_mask, check_mask,
    output fifo_valid, fifo_data,
    input  fifo_pop,
    input  req_valid, req_x, req_y, req_sizex, req_sizey, req_set_mask, req_use_mask,
    output req_accept,
    input  data_valid_l, data_pixel_l, data_valid_r, data_pixel_r,
    output data_accept_l, data_accept_r,
    output engine_done,
    input  busy, done
  );

  modport slave (
    input  start, set_mask, check_mask,
    input  fifo_valid, fifo_data,
    output fifo_pop,
    output req_valid, req_x, req_y, req_sizex, req_sizey, req_set_mask, req_use_mask,
    input  req_accept,
    output data_valid_l, data_pixel_l, data_valid_r, data_pixel_r,
    input  data_accept_l, data_accept_r,
    input  engine_done,
    output busy, done
  );
endinterface

// File: rtl/gpu_cpuvram_cmd_unpack.sv
// GP0 A0h front end: pops the 3-word header, normalises the rectangle, issues one
// request to the write engine, then streams each data word as a left/right pixel pair.
module gpu_cpuvram_cmd_unpack #(
  parameter int FIFO_W = 32,
  parameter int CNT_W  = 19
) (
  input logic                     clk,
  input logic                     rst,
  gpu_cpuvram_cmd_unpack_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, XY, SIZE, CALC, REQ, DATA, DRAIN
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic             set_mask_q;
  logic             use_mask_q;
  logic [9:0]       x_q;
  logic [8:0]       y_q;
  logic [10:0]      sizex_q;
  logic [10:0]      sizey_q;
  logic [CNT_W-1:0] cnt_q;

  logic             pop;
  logic             req_valid;
  logic             data_valid;
  logic             done;

  // Raw 0 wraps to the maximum: width 1..1024, height 1..512.
  function automatic logic [10:0] norm_sizex(input logic [15:0] raw);
    logic [9:0] m;
    m = raw[9:0] - 10'd1;
    return {1'b0, m} + 11'd1;
  endfunction

  function automatic logic [10:0] norm_sizey(input logic [15:0] raw);
    logic [8:0] m;
    m = raw[8:0] - 9'd1;
    return {2'b00, m} + 11'd1;
  endfunction

  // Pixel pairs per rectangle, rounding an odd pixel count up to a whole word.
  function automatic logic [CNT_W-1:0] word_count(input logic [10:0] sx,
                                                  input logic [10:0] sy);
    logic [21:0] p;
    p = {11'd0, sx} * {11'd0, sy};
    p = (p + 22'd1) >> 1;
    return p[CNT_W-1:0];
  endfunction

  always_comb begin
    state_nxt  = state;
    pop        = 1'b0;
    req_valid  = 1'b0;
    data_valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = CMD;
      end
      CMD: begin
        pop = bus.fifo_valid;
        if (pop) state_nxt = XY;
      end
      XY: begin
        pop = bus.fifo_valid;
        if (pop) state_nxt = SIZE;
      end
      SIZE: begin
        pop = bus.fifo_valid;
        if (pop) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (bus.req_accept) state_nxt = DATA;
      end
      DATA: begin
        // A word is consumed only when both halves are taken together.
        data_valid = bus.fifo_valid;
        pop        = bus.fifo_valid & bus.data_accept_l & bus.data_accept_r;
        if (pop && cnt_q == CNT_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.engine_done) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      set_mask_q <= 1'b0;
      use_mask_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      sizex_q    <= '0;
      sizey_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            set_mask_q <= bus.set_mask;
            use_mask_q <= bus.check_mask;
          end
        end
        XY: begin
          if (pop) begin
            x_q <= bus.fifo_data[9:0];
            y_q <= bus.fifo_data[24:16];
          end
        end
        SIZE: begin
          if (pop) begin
            sizex_q <= norm_sizex(bus.fifo_data[15:0]);
            sizey_q <= norm_sizey(bus.fifo_data[31:16]);
          end
        end
        CALC: cnt_q <= word_count(sizex_q, sizey_q);
        DATA: begin
          if (pop) cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.fifo_pop     = pop;
  assign bus.req_valid    = req_valid;
  assign bus.req_x        = {6'd0, x_q};
  assign bus.req_y        = {7'd0, y_q};
  assign bus.req_sizex    = {5'd0, sizex_q};
  assign bus.req_sizey    = {5'd0, sizey_q};
  assign bus.req_set_mask = set_mask_q;
  assign bus.req_use_mask = use_mask_q;
  assign bus.data_valid_l = data_valid;
  assign bus.data_valid_r = data_valid;
  assign bus.data_pixel_l = bus.fifo_data[15:0];
  assign bus.data_pixel_r = bus.fifo_data[FIFO_W-1:16];
  assign bus.busy         = (state != IDLE);
  assign bus.done         = done;

endmodule
